// File: rtl/time_entry_buffer.sv
// time_entry_buffer: collects keypad digits into an MM:SS buffer, validates it
// on start and drives the parallel-load strobe of the BCD down-counter chain.
// Optional idle auto-clear in ENTRY is enabled by defining TIME_ENTRY_TIMEOUT_EN.
module time_entry_buffer #(
  parameter int MAX_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock_i,
  input  logic       clear_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  input  logic       start_i,
  input  logic       cancel_i,
  input  logic       timer_done_i,
  output logic [3:0] sec_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] min_tens_o,
  output logic       loadn_o,
  output logic       load_en_o,
  output logic [2:0] digit_count_o,
  output logic       rejected_o,
  output logic       locked_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_LOAD, ST_LOCKED} state_e;

  state_e     state_q, state_d;
  logic [3:0] so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
  logic [2:0] count_q, count_d;
  logic       loadn_q, loadn_d, load_en_q, load_en_d;
  logic       rejected_q, rejected_d, locked_q, locked_d;
  logic       key_q, key_prev_q, start_q, start_prev_q, done_q, done_prev_q;
  logic       key_rise, start_rise, done_rise, key_accept, start_bad;

  // Rises are seen one cycle late, from the first registered sample of each input.
  assign key_rise   = key_q & ~key_prev_q;
  assign start_rise = start_q & ~start_prev_q;
  assign done_rise  = done_q & ~done_prev_q;
  assign key_accept = key_rise && (key_code_i <= 4'd9) && (count_q < 3'(MAX_DIGITS));
  assign start_bad  = (count_q == 3'd0) || (st_q > 4'd5);

`ifdef TIME_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  assign tmo_hit = (state_q == ST_ENTRY) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // Next-state and next-output computation for the entry/load/lock sequence.
  always_comb begin
    state_d    = state_q;
    so_d       = so_q;
    st_d       = st_q;
    mo_d       = mo_q;
    mt_d       = mt_q;
    count_d    = count_q;
    loadn_d    = 1'b1;
    load_en_d  = 1'b0;
    rejected_d = 1'b0;
    locked_d   = locked_q;
`ifdef TIME_ENTRY_TIMEOUT_EN
    tmo_d      = '0;
`endif
    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (cancel_i
`ifdef TIME_ENTRY_TIMEOUT_EN
            || tmo_hit
`endif
           ) begin
          {mt_d, mo_d, st_d, so_d} = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end else if (start_rise) begin
          // A key rising in the same cycle is dropped; start takes precedence.
          if (start_bad) begin
            rejected_d = 1'b1;
          end else begin
            state_d   = ST_LOAD;
            loadn_d   = 1'b0;
            load_en_d = 1'b1;
          end
        end else if (key_accept) begin
          mt_d    = mo_q;
          mo_d    = st_q;
          st_d    = so_q;
          so_d    = key_code_i;
          count_d = count_q + 3'd1;
          state_d = ST_ENTRY;
        end
`ifdef TIME_ENTRY_TIMEOUT_EN
        if (state_q == ST_ENTRY && state_d == ST_ENTRY && !key_accept)
          tmo_d = tmo_q + TW'(1);
`endif
      end
      ST_LOAD: begin
        state_d  = ST_LOCKED;
        locked_d = 1'b1;
      end
      ST_LOCKED: begin
        if (done_rise) begin
          {mt_d, mo_d, st_d, so_d} = '0;
          count_d  = '0;
          state_d  = ST_IDLE;
          locked_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, buffer, registered outputs and edge-detect pipeline.
  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q      <= ST_IDLE;
      {mt_q, mo_q, st_q, so_q} <= '0;
      count_q      <= '0;
      loadn_q      <= 1'b1;
      load_en_q    <= 1'b0;
      rejected_q   <= 1'b0;
      locked_q     <= 1'b0;
      key_q        <= 1'b0;
      key_prev_q   <= 1'b0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      done_q       <= 1'b0;
      done_prev_q  <= 1'b0;
`ifdef TIME_ENTRY_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      so_q         <= so_d;
      st_q         <= st_d;
      mo_q         <= mo_d;
      mt_q         <= mt_d;
      count_q      <= count_d;
      loadn_q      <= loadn_d;
      load_en_q    <= load_en_d;
      rejected_q   <= rejected_d;
      locked_q     <= locked_d;
      key_q        <= key_valid_i;
      key_prev_q   <= key_q;
      start_q      <= start_i;
      start_prev_q <= start_q;
      done_q       <= timer_done_i;
      done_prev_q  <= done_q;
`ifdef TIME_ENTRY_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign sec_ones_o    = so_q;
  assign sec_tens_o    = st_q;
  assign min_ones_o    = mo_q;
  assign min_tens_o    = mt_q;
  assign loadn_o       = loadn_q;
  assign load_en_o     = load_en_q;
  assign digit_count_o = count_q;
  assign rejected_o    = rejected_q;
  assign locked_o      = locked_q;

endmodule

// File: tb/tb_time_entry_buffer.sv
// Bench for time_entry_buffer: directed scenarios followed by random stimulus,
// all checked every cycle against a decimal-arithmetic reference model.
module tb_time_entry_buffer;
  localparam int TMO = 8;

  logic       clock = 1'b0;
  logic       clear_i, key_valid_i, start_i, cancel_i, timer_done_i;
  logic [3:0] key_code_i;
  logic [3:0] sec_ones_o, sec_tens_o, min_ones_o, min_tens_o;
  logic       loadn_o, load_en_o, rejected_o, locked_o;
  logic [2:0] digit_count_o;

  int total = 0;
  int bad   = 0;

  // Reference model: buffer held as a decimal number, MM:SS digits by arithmetic.
  int m_buf, m_n, m_mode, m_idle;  // mode: 0 idle, 1 entry, 2 load, 3 locked
  int m_loadn, m_en, m_rej, m_lock;
  int hk1, hk2, hs1, hs2, hd1, hd2;

  time_entry_buffer #(.MAX_DIGITS(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clock_i(clock), .clear_i(clear_i), .key_valid_i(key_valid_i),
    .key_code_i(key_code_i), .start_i(start_i), .cancel_i(cancel_i),
    .timer_done_i(timer_done_i), .sec_ones_o(sec_ones_o), .sec_tens_o(sec_tens_o),
    .min_ones_o(min_ones_o), .min_tens_o(min_tens_o), .loadn_o(loadn_o),
    .load_en_o(load_en_o), .digit_count_o(digit_count_o),
    .rejected_o(rejected_o), .locked_o(locked_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear_buf();
    m_buf = 0; m_n = 0; m_mode = 0;
  endtask

  task automatic model_step();
    int kev, sev, dev, accepted;
    kev = (hk1 == 1 && hk2 == 0);
    sev = (hs1 == 1 && hs2 == 0);
    dev = (hd1 == 1 && hd2 == 0);
    accepted = 0;
    if (clear_i) begin
      model_clear_buf();
      m_loadn = 1; m_en = 0; m_rej = 0; m_lock = 0; m_idle = 0;
      hk1 = 0; hk2 = 0; hs1 = 0; hs2 = 0; hd1 = 0; hd2 = 0;
      return;
    end
    m_loadn = 1; m_en = 0; m_rej = 0;
    if (m_mode == 0 || m_mode == 1) begin
      int was_entry, timed_out;
      was_entry = (m_mode == 1);
      timed_out = 0;
`ifdef TIME_ENTRY_TIMEOUT_EN
      timed_out = was_entry && (m_idle == TMO - 1);
`endif
      if (cancel_i || timed_out) model_clear_buf();
      else if (sev) begin
        if (m_n == 0 || (m_buf / 10) % 10 > 5) m_rej = 1;
        else begin m_mode = 2; m_loadn = 0; m_en = 1; end
      end else if (kev && key_code_i < 10 && m_n < 4) begin
        m_buf = (m_buf * 10 + int'(key_code_i)) % 10000;
        m_n++;
        m_mode = 1;
        accepted = 1;
      end
      m_idle = (was_entry && m_mode == 1 && !accepted) ? m_idle + 1 : 0;
    end else if (m_mode == 2) begin
      m_mode = 3; m_lock = 1; m_idle = 0;
    end else begin
      m_idle = 0;
      if (dev) begin model_clear_buf(); m_lock = 0; end
    end
    hk2 = hk1; hk1 = int'(key_valid_i);
    hs2 = hs1; hs1 = int'(start_i);
    hd2 = hd1; hd1 = int'(timer_done_i);
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    chk("sec_ones", 32'(sec_ones_o), m_buf % 10);
    chk("sec_tens", 32'(sec_tens_o), (m_buf / 10) % 10);
    chk("min_ones", 32'(min_ones_o), (m_buf / 100) % 10);
    chk("min_tens", 32'(min_tens_o), m_buf / 1000);
    chk("count", 32'(digit_count_o), m_n);
    chk("loadn", 32'(loadn_o), m_loadn);
    chk("load_en", 32'(load_en_o), m_en);
    chk("rejected", 32'(rejected_o), m_rej);
    chk("locked", 32'(locked_o), m_lock);
  endtask

  task automatic press(input int k);
    key_valid_i = 1'b1; key_code_i = 4'(k);
    tick(); tick();
    key_valid_i = 1'b0;
    tick(); tick();
  endtask

  task automatic chk_digits(input string tag, input int mt, input int mo, input int st, input int so);
    chk({tag, "_mt"}, 32'(min_tens_o), mt);
    chk({tag, "_mo"}, 32'(min_ones_o), mo);
    chk({tag, "_st"}, 32'(sec_tens_o), st);
    chk({tag, "_so"}, 32'(sec_ones_o), so);
  endtask

  initial begin
    clear_i = 1'b1; key_valid_i = 1'b0; key_code_i = 4'd0;
    start_i = 1'b0; cancel_i = 1'b0; timer_done_i = 1'b0;
    m_loadn = 1; m_en = 0; m_rej = 0; m_lock = 0; m_idle = 0;
    hk1 = 0; hk2 = 0; hs1 = 0; hs2 = 0; hd1 = 0; hd2 = 0;
    model_clear_buf();
    tick(); tick();
    chk_digits("rst", 0, 0, 0, 0);
    chk("rst_loadn", 32'(loadn_o), 1);
    chk("rst_locked", 32'(locked_o), 0);
    clear_i = 1'b0;
    tick();

    // 1,3,0 then start: load pulse two cycles after start rises, then locked.
    press(1); press(3); press(0);
    chk_digits("k130", 0, 1, 3, 0);
    chk("k130_count", 32'(digit_count_o), 3);
    start_i = 1'b1;
    tick(); chk("ld_early", 32'(loadn_o), 1);
    tick(); chk("ld_pulse", 32'(loadn_o), 0); chk("ld_en", 32'(load_en_o), 1);
    start_i = 1'b0;
    tick(); chk("ld_end", 32'(loadn_o), 1); chk("ld_locked", 32'(locked_o), 1);

    // Locked: keys and cancel ignored; done releases.
    press(7);
    cancel_i = 1'b1; tick(); cancel_i = 1'b0; tick();
    chk_digits("lock_hold", 0, 1, 3, 0);
    timer_done_i = 1'b1; tick(); tick(); timer_done_i = 1'b0; tick();
    chk_digits("done", 0, 0, 0, 0);
    chk("done_locked", 32'(locked_o), 0);
    chk("done_count", 32'(digit_count_o), 0);

    // Overflow and non-digit keys are ignored.
    press(1); press(2); press(3); press(4); press(5); press(12);
    chk_digits("full", 1, 2, 3, 4);
    chk("full_count", 32'(digit_count_o), 4);
    cancel_i = 1'b1; tick(); cancel_i = 1'b0; tick();

    // Invalid seconds-tens and empty buffer are rejected.
    press(9); press(9);
    start_i = 1'b1; tick(); tick();
    chk("rej_tens", 32'(rejected_o), 1); chk("rej_loadn", 32'(loadn_o), 1);
    start_i = 1'b0; tick();
    chk("rej_pulse", 32'(rejected_o), 0); chk("rej_count", 32'(digit_count_o), 2);
    cancel_i = 1'b1; tick(); cancel_i = 1'b0; tick();
    start_i = 1'b1; tick(); tick();
    chk("rej_empty", 32'(rejected_o), 1);
    start_i = 1'b0; tick();

    // Held key gives one digit; cancel beats a simultaneous key rise.
    key_valid_i = 1'b1; key_code_i = 4'd6;
    for (int i = 0; i < 10; i++) tick();
    key_valid_i = 1'b0; tick(); tick();
    chk("held_count", 32'(digit_count_o), 1);
    chk("held_so", 32'(sec_ones_o), 6);
    key_valid_i = 1'b1; key_code_i = 4'd5; tick();
    cancel_i = 1'b1; tick();
    chk("cancel_key", 32'(digit_count_o), 0);
    cancel_i = 1'b0; key_valid_i = 1'b0; tick(); tick();

    // Clear during the load cycle aborts.
    press(2);
    start_i = 1'b1; tick(); tick();
    chk("abort_ld", 32'(loadn_o), 0);
    clear_i = 1'b1; start_i = 1'b0; tick();
    chk("abort_loadn", 32'(loadn_o), 1);
    chk("abort_en", 32'(load_en_o), 0);
    chk_digits("abort", 0, 0, 0, 0);
    clear_i = 1'b0; tick();

`ifdef TIME_ENTRY_TIMEOUT_EN
    press(4);
    for (int i = 0; i < 6; i++) tick();
    chk("tmo_count", 32'(digit_count_o), 0);
    chk("tmo_so", 32'(sec_ones_o), 0);
`endif

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) key_valid_i = ~key_valid_i;
      if (!key_valid_i)
        key_code_i = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) start_i = ~start_i;
      cancel_i = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) timer_done_i = ~timer_done_i;
      clear_i = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/time_entry_buffer.md
Name: time_entry_buffer

Overview:
- Upstream stage of the microwave timer digit chain. Collects decimal keypad digits into a 4-digit MM:SS buffer by shifting each new digit in from the right.
- On start, validates the buffer and drives the parallel-load inputs of the four cascaded BCD down-counter digits: shared active-low load strobe, shared enable, per-digit 4-bit data.
- Locks out key entry while the timer runs.

Parameters:
- MAX_DIGITS, 4, number of digits accepted before further keys are ignored (1..4).
- TIMEOUT_CYCLES, 1000, idle cycles in ENTRY before auto-clear (used only with the optional feature).

Ports:
- clock  input  1  system clock; all state changes on posedge.
- clear  input  1  synchronous, active-high reset.
- key_valid  input  1  keypad strobe, level; one key accepted per rising edge.
- key_code  input  4  key value; 0..9 are digits, 10..15 are ignored.
- start  input  1  request to load counters; acted on at rising edge.
- cancel  input  1  clears buffer in IDLE/ENTRY; ignored in LOCKED.
- timer_done  input  1  from downstream chain (all digits zero); releases LOCKED.
- sec_ones, sec_tens, min_ones, min_tens  output  4 each  buffered BCD digits, wired to counter data_in.
- loadn  output  1  active-low load strobe to all counters.
- load_en  output  1  counter enable asserted with loadn, because counters load only while enabled.
- digit_count  output  3  digits entered, 0..MAX_DIGITS.
- rejected  output  1  one-cycle pulse on invalid start.
- locked  output  1  high in LOCKED.

Behaviour:
- Reset, when clear=1 at posedge:
  - all digits = 0, digit_count = 0
  - loadn = 1, load_en = 0, rejected = 0, locked = 0
  - state = IDLE, edge-detect registers = 0
  - clear has priority over every other input.
- Edge detection: key_valid, start and timer_done are registered each cycle. Events are key_rise, start_rise and done_rise; each is recognised 1 cycle after its input rises.
- States: IDLE, ENTRY, LOAD, LOCKED.
- Digit entry, on key_rise with key_code <= 9 in IDLE or ENTRY:
  - shift: min_tens <= min_ones, min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= key_code
  - digit_count increments; state becomes ENTRY.
  - If digit_count == MAX_DIGITS, the key is ignored and the buffer is unchanged.
  - key_code >= 10 is always ignored.
- cancel in IDLE or ENTRY: digits = 0, count = 0, state becomes IDLE. cancel beats a simultaneous key_rise or start_rise.
- start_rise in IDLE or ENTRY:
  - Invalid if digit_count == 0 or sec_tens > 5. Then rejected = 1 for one cycle and state/buffer are unchanged.
  - Otherwise the next state is LOAD.
  - A key_rise in the same cycle as start_rise is discarded; start wins.
- LOAD, exactly one cycle: loadn = 0 and load_en = 1, with digits stable on the outputs. Next state is LOCKED.
- LOCKED:
  - locked = 1; key_rise, start_rise and cancel are ignored.
  - Digit outputs hold their values.
  - On done_rise: digits = 0, count = 0, state becomes IDLE, locked = 0 on the following cycle.
- Outputs are registered. The loadn low pulse appears 2 cycles after the start input rises: 1 cycle for edge detect, 1 cycle for the transition into LOAD.
- done_rise outside LOCKED is ignored.
- clear asserted during LOAD or LOCKED aborts immediately to the reset values. loadn is never held low past the clear cycle.

Optional Feature:
- Macro: TIME_ENTRY_TIMEOUT_EN.
- Defined:
  - A counter, wide enough for TIMEOUT_CYCLES, runs in ENTRY and resets to 0 on every accepted key.
  - On reaching TIMEOUT_CYCLES-1 it performs the cancel action: buffer zeroed, state becomes IDLE.
  - The counter is held at 0 outside ENTRY.
- Not defined: no counter logic; ENTRY persists indefinitely.

Test Plan:
- Reset, then key pulses 1,3,0 then start -> digits min_tens..sec_ones = 0,1,3,0 and digit_count = 3; loadn = 0 and load_en = 1 for exactly 1 cycle, 2 cycles after start rises; locked = 1 afterwards.
- Keys 1,2,3,4,5 -> buffer 1,2,3,4 and digit_count = 4; the fifth key is ignored. Key_code 12 is also ignored.
- Keys 9,9 (sec_tens = 9) then start -> rejected pulses 1 cycle, no loadn pulse, state stays ENTRY; start with 0 digits -> rejected.
- In LOCKED: keys 7 and cancel -> digits unchanged. timer_done rises -> digits = 0, count = 0, locked = 0.
- key_valid held high for 10 cycles -> one digit accepted. Simultaneous cancel and key_rise -> buffer cleared.
- clear asserted during the LOAD cycle -> next cycle loadn = 1 and all outputs 0. With TIME_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES = 8: one key, then 8 idle cycles -> buffer cleared and state IDLE.
